// File: rtl/pms_acpi_boot_ctrl_if.sv
//------------------------------------------------------------------------------
// pms_acpi_boot_ctrl_if
// Host register port of the PMS boot/ACPI control block.
//   reg_req_i   : access request (one cycle per access)
//   reg_we_i    : 1 = write, 0 = read
//   reg_addr_i  : byte address, word aligned
//   reg_wdata_i : write data
//   reg_rdata_o : read data, valid with reg_ready_o
//   reg_ready_o : completion strobe, one cycle after the request
// Modports: master = host side, slave = control block side.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface pms_acpi_boot_ctrl_if;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        reg_ready_o;

    modport master (
        output reg_req_i,
        output reg_we_i,
        output reg_addr_i,
        output reg_wdata_i,
        input  reg_rdata_o,
        input  reg_ready_o
    );

    modport slave (
        input  reg_req_i,
        input  reg_we_i,
        input  reg_addr_i,
        input  reg_wdata_i,
        output reg_rdata_o,
        output reg_ready_o
    );
endinterface

// File: rtl/pms_acpi_boot_ctrl.sv
//------------------------------------------------------------------------------
// pms_acpi_boot_ctrl
// Boot control/status registers plus the ACPI power-button sleep-state FSM
// (short press in S5 powers on, long press in S0 forces power down).
//
// Optional feature macro: PMS_PWRBTN_IRQ_EN
//   defined   : sticky short-press event flag on irq_o, W1C at PWRBTN_EVT
//   undefined : no flag logic, irq_o = 0, PWRBTN_EVT reads 0
//
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   reg_if (slave)       : host register port (see pms_acpi_boot_ctrl_if)
//   pwr_btn_ni           : power button, active low, asynchronous
//   eoc_i, exit_status_i : end-of-computation and exit code from the core
//   bootmode_o           : boot mode
//   boot_addr_o          : core entry point
//   fetch_en_o           : core fetch enable
//   sleep_state_o        : 0 = S5, 1 = S0
//   sys_pwrok_o          : high while in S0
//   irq_o                : power-button event interrupt
//
// Register map: 0x00 BOOTMODE, 0x04 BOOT_ADDR, 0x08 FETCH_EN, 0x0C STATUS,
//               0x10 EXIT_STATUS, 0x14 PWRBTN_EVT
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pms_acpi_boot_ctrl #(
    parameter int unsigned DEBOUNCE_CYC   = 16,
    parameter int unsigned LONG_PRESS_CYC = 4000,
    parameter logic [31:0] BOOT_ADDR_RST  = 32'h1C00_8080
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pms_acpi_boot_ctrl_if.slave reg_if,
    input  logic                pwr_btn_ni,
    input  logic                eoc_i,
    input  logic [31:0]         exit_status_i,
    output logic [1:0]          bootmode_o,
    output logic [31:0]         boot_addr_o,
    output logic                fetch_en_o,
    output logic [1:0]          sleep_state_o,
    output logic                sys_pwrok_o,
    output logic                irq_o
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned HOLD_W = 16;

    localparam logic [4:0] ADDR_BOOTMODE  = 5'h00;
    localparam logic [4:0] ADDR_BOOT_ADDR = 5'h04;
    localparam logic [4:0] ADDR_FETCH_EN  = 5'h08;
    localparam logic [4:0] ADDR_STATUS    = 5'h0C;
    localparam logic [4:0] ADDR_EXIT      = 5'h10;
    localparam logic [4:0] ADDR_PWRBTN    = 5'h14;

    typedef enum logic [2:0] {
        ST_S5       = 3'd0,
        ST_S5_PRESS = 3'd1,
        ST_S0       = 3'd2,
        ST_S0_PRESS = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    // Registers
    logic [1:0]        r_bootmode;
    logic [31:0]       r_boot_addr;
    logic              r_fetch_en;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic [31:0]       r_exit_status;
    logic              r_eoc_s1, r_eoc_s2, r_eoc_s3;
    logic              r_btn_s1, r_btn_s2;
    logic              r_pd;
    logic [DB_W-1:0]   r_db_cnt;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [1:0]        r_sleep_state;
    logic              r_pwrok;

    // Wires
    logic        w_wr;
    logic        w_press_sync;
    logic        w_force_off;
    logic [31:0] w_rdata;

    assign w_wr         = reg_if.reg_req_i && reg_if.reg_we_i;
    assign w_press_sync = ~r_btn_s2;
    // Long press has been held LONG_PRESS_CYC cycles in S0_PRESS
    assign w_force_off  = (r_state == ST_S0_PRESS) && r_pd &&
                          (r_hold_cnt >= HOLD_W'(LONG_PRESS_CYC - 1));

`ifdef PMS_PWRBTN_IRQ_EN
    logic r_evt_flag;
    logic w_short_evt;

    assign w_short_evt = (r_state == ST_S0_PRESS) && !r_pd;

    // Sticky event flag; a new event beats a simultaneous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_evt_flag <= 1'b0;
        end else if (w_short_evt) begin
            r_evt_flag <= 1'b1;
        end else if (w_wr && (reg_if.reg_addr_i == ADDR_PWRBTN) && reg_if.reg_wdata_i[0]) begin
            r_evt_flag <= 1'b0;
        end
    end

    assign irq_o = r_evt_flag;
`else
    assign irq_o = 1'b0;
`endif

    // Read data mux
    always_comb begin
        w_rdata = 32'h0;
        case (reg_if.reg_addr_i)
            ADDR_BOOTMODE:  w_rdata = {30'h0, r_bootmode};
            ADDR_BOOT_ADDR: w_rdata = r_boot_addr;
            ADDR_FETCH_EN:  w_rdata = {31'h0, r_fetch_en};
            ADDR_STATUS:    w_rdata = {28'h0, r_pwrok, r_sleep_state, r_eoc_s2};
            ADDR_EXIT:      w_rdata = r_exit_status;
`ifdef PMS_PWRBTN_IRQ_EN
            ADDR_PWRBTN:    w_rdata = {31'h0, r_evt_flag};
`endif
            default:        w_rdata = 32'h0;
        endcase
    end

    // Register port and boot registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bootmode  <= 2'd0;
            r_boot_addr <= BOOT_ADDR_RST;
            r_fetch_en  <= 1'b0;
            r_rdata     <= 32'h0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= reg_if.reg_req_i;
            if (reg_if.reg_req_i) begin
                r_rdata <= reg_if.reg_we_i ? 32'h0 : w_rdata;
            end
            if (w_wr && (reg_if.reg_addr_i == ADDR_BOOTMODE)) begin
                r_bootmode <= reg_if.reg_wdata_i[1:0];
            end
            if (w_wr && (reg_if.reg_addr_i == ADDR_BOOT_ADDR)) begin
                r_boot_addr <= reg_if.reg_wdata_i;
            end
            // Forced power-down overrides a concurrent FETCH_EN write
            if (w_force_off) begin
                r_fetch_en <= 1'b0;
            end else if (w_wr && (reg_if.reg_addr_i == ADDR_FETCH_EN)) begin
                r_fetch_en <= reg_if.reg_wdata_i[0];
            end
        end
    end

    // EOC synchronizer and exit status capture on its rising edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_eoc_s1      <= 1'b0;
            r_eoc_s2      <= 1'b0;
            r_eoc_s3      <= 1'b0;
            r_exit_status <= 32'h0;
        end else begin
            r_eoc_s1 <= eoc_i;
            r_eoc_s2 <= r_eoc_s1;
            r_eoc_s3 <= r_eoc_s2;
            if (r_eoc_s2 && !r_eoc_s3) begin
                r_exit_status <= exit_status_i;
            end
        end
    end

    // Button synchronizer and debounce: pd follows press after DEBOUNCE_CYC
    // consecutive cycles of disagreement; any return to agreement restarts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_btn_s1 <= 1'b1;
            r_btn_s2 <= 1'b1;
            r_pd     <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_btn_s1 <= pwr_btn_ni;
            r_btn_s2 <= r_btn_s1;
            if (w_press_sync == r_pd) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                r_pd     <= w_press_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Sleep-state FSM with registered sleep state / pwrok
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_S5;
            r_hold_cnt    <= '0;
            r_sleep_state <= 2'd0;
            r_pwrok       <= 1'b0;
        end else begin
            case (r_state)
                ST_S5: begin
                    if (r_pd) begin
                        r_state    <= ST_S5_PRESS;
                        r_hold_cnt <= '0;
                    end
                end
                ST_S5_PRESS: begin
                    if (!r_pd) begin
                        r_state       <= ST_S0;
                        r_sleep_state <= 2'd1;
                        r_pwrok       <= 1'b1;
                    end
                end
                ST_S0: begin
                    if (r_pd) begin
                        r_state    <= ST_S0_PRESS;
                        r_hold_cnt <= '0;
                    end
                end
                ST_S0_PRESS: begin
                    if (!r_pd) begin
                        r_state <= ST_S0;
                    end else if (w_force_off) begin
                        r_state       <= ST_WAIT_REL;
                        r_sleep_state <= 2'd0;
                        r_pwrok       <= 1'b0;
                    end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_WAIT_REL: begin
                    // Held button after forced off must not re-power the system
                    if (!r_pd) begin
                        r_state <= ST_S5;
                    end
                end
                default: begin
                    r_state       <= ST_S5;
                    r_sleep_state <= 2'd0;
                    r_pwrok       <= 1'b0;
                end
            endcase
        end
    end

    assign bootmode_o         = r_bootmode;
    assign boot_addr_o        = r_boot_addr;
    assign fetch_en_o         = r_fetch_en;
    assign sleep_state_o      = r_sleep_state;
    assign sys_pwrok_o        = r_pwrok;
    assign reg_if.reg_rdata_o = r_rdata;
    assign reg_if.reg_ready_o = r_ready;

endmodule

// File: tb/tb_pms_acpi_boot_ctrl.sv
//------------------------------------------------------------------------------
// tb_pms_acpi_boot_ctrl
// Directed self-checking bench for pms_acpi_boot_ctrl (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pms_acpi_boot_ctrl;

`ifdef PMS_PWRBTN_IRQ_EN
    localparam logic EXP_IRQ = 1'b1;
`else
    localparam logic EXP_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pwr_btn_ni;
    logic        eoc_i;
    logic [31:0] exit_status_i;
    logic [1:0]  bootmode_o;
    logic [31:0] boot_addr_o;
    logic        fetch_en_o;
    logic [1:0]  sleep_state_o;
    logic        sys_pwrok_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pms_acpi_boot_ctrl_if reg_if ();

    pms_acpi_boot_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .reg_if        (reg_if),
        .pwr_btn_ni    (pwr_btn_ni),
        .eoc_i         (eoc_i),
        .exit_status_i (exit_status_i),
        .bootmode_o    (bootmode_o),
        .boot_addr_o   (boot_addr_o),
        .fetch_en_o    (fetch_en_o),
        .sleep_state_o (sleep_state_o),
        .sys_pwrok_o   (sys_pwrok_o),
        .irq_o         (irq_o)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One register access issued at a falling edge; returns the response
    // sampled one cycle later.
    task automatic reg_xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic rdy);
        reg_if.reg_req_i   = 1'b1;
        reg_if.reg_we_i    = we;
        reg_if.reg_addr_i  = addr;
        reg_if.reg_wdata_i = wdata;
        @(negedge clk);
        reg_if.reg_req_i   = 1'b0;
        reg_if.reg_we_i    = 1'b0;
        rdata = reg_if.reg_rdata_o;
        rdy   = reg_if.reg_ready_o;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [7] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};
        logic [31:0] exps  [7] = '{32'h0, 32'h1C00_8080, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] rd;
        logic        rdy;
        rst = 1'b1;
        cycles(3);
        n_checks++;
        if ({bootmode_o, boot_addr_o, fetch_en_o, sleep_state_o, sys_pwrok_o, irq_o,
             reg_if.reg_ready_o, reg_if.reg_rdata_o} !== {2'd0, 32'h1C00_8080, 1'b0, 2'd0, 3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: bm=%0d ba=%h fe=%0b ss=%0d pok=%0b irq=%0b rdy=%0b rd=%h, expected bm=0 ba=1c008080 rest 0",
                     bootmode_o, boot_addr_o, fetch_en_o, sleep_state_o, sys_pwrok_o, irq_o,
                     reg_if.reg_ready_o, reg_if.reg_rdata_o);
        end
        rst = 1'b0;
        cycles(1);
        for (int i = 0; i < 7; i++) begin
            reg_xfer(1'b0, addrs[i], 32'h0, rd, rdy);
            n_checks++;
            if (rdy !== 1'b1 || rd !== exps[i]) begin
                n_fail++;
                $display("FAIL reset_read[%h]: rdy=%0b data=%h, expected rdy=1 data=%h", addrs[i], rdy, rd, exps[i]);
            end
        end
        cycles(1);
        n_checks++;
        if (reg_if.reg_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_single_pulse: rdy=%0b, expected 0", reg_if.reg_ready_o);
        end
    endtask

    task automatic test_reg_write();
        logic [4:0]  addrs [5] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h18};
        logic [31:0] exps  [5] = '{32'h3, 32'h1C00_0880, 32'h1, 32'h0, 32'h0};
        logic [31:0] rd;
        logic        rdy;
        reg_xfer(1'b1, 5'h00, 32'hFFFF_FFFF, rd, rdy);
        n_checks++;
        if (bootmode_o !== 2'd3 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_bootmode: bm=%0d rdy=%0b, expected bm=3 rdy=1", bootmode_o, rdy);
        end
        reg_xfer(1'b1, 5'h04, 32'h1C00_0880, rd, rdy);
        n_checks++;
        if (boot_addr_o !== 32'h1C00_0880) begin
            n_fail++;
            $display("FAIL wr_boot_addr: ba=%h, expected 1c000880", boot_addr_o);
        end
        reg_xfer(1'b1, 5'h08, 32'h1, rd, rdy);
        n_checks++;
        if (fetch_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_fetch_en: fe=%0b, expected 1", fetch_en_o);
        end
        // Writes to read-only and unmapped addresses must be ignored
        reg_xfer(1'b1, 5'h0C, 32'hF, rd, rdy);
        reg_xfer(1'b1, 5'h18, 32'hFFFF_FFFF, rd, rdy);
        for (int i = 0; i < 5; i++) begin
            reg_xfer(1'b0, addrs[i], 32'h0, rd, rdy);
            n_checks++;
            if (rdy !== 1'b1 || rd !== exps[i]) begin
                n_fail++;
                $display("FAIL readback[%h]: rdy=%0b data=%h, expected rdy=1 data=%h", addrs[i], rdy, rd, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        reg_if.reg_req_i  = 1'b1;
        reg_if.reg_we_i   = 1'b0;
        reg_if.reg_addr_i = 5'h04;
        @(negedge clk);
        n_checks++;
        if (reg_if.reg_ready_o !== 1'b1 || reg_if.reg_rdata_o !== 32'h1C00_0880) begin
            n_fail++;
            $display("FAIL b2b_first: rdy=%0b data=%h, expected rdy=1 data=1c000880", reg_if.reg_ready_o, reg_if.reg_rdata_o);
        end
        reg_if.reg_addr_i = 5'h00;
        @(negedge clk);
        n_checks++;
        if (reg_if.reg_ready_o !== 1'b1 || reg_if.reg_rdata_o !== 32'h3) begin
            n_fail++;
            $display("FAIL b2b_second: rdy=%0b data=%h, expected rdy=1 data=3", reg_if.reg_ready_o, reg_if.reg_rdata_o);
        end
        reg_if.reg_we_i    = 1'b1;
        reg_if.reg_wdata_i = 32'h2;
        @(negedge clk);
        reg_if.reg_req_i = 1'b0;
        reg_if.reg_we_i  = 1'b0;
        n_checks++;
        if (reg_if.reg_ready_o !== 1'b1 || bootmode_o !== 2'd2) begin
            n_fail++;
            $display("FAIL b2b_write: rdy=%0b bm=%0d, expected rdy=1 bm=2", reg_if.reg_ready_o, bootmode_o);
        end
        @(negedge clk);
        n_checks++;
        if (reg_if.reg_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_drop: rdy=%0b, expected 0", reg_if.reg_ready_o);
        end
    endtask

    // Press 100 cycles in S5; S0 is reached exactly 19 cycles after release
    task automatic test_power_on(input logic exp_fetch);
        logic [31:0] rd;
        logic        rdy;
        pwr_btn_ni = 1'b0;
        cycles(100);
        n_checks++;
        if (sleep_state_o !== 2'd0 || sys_pwrok_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pwron_during_press: ss=%0d pok=%0b, expected 0/0", sleep_state_o, sys_pwrok_o);
        end
        pwr_btn_ni = 1'b1;
        cycles(18);
        n_checks++;
        if (sleep_state_o !== 2'd0 || sys_pwrok_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pwron_early: ss=%0d pok=%0b, expected 0/0", sleep_state_o, sys_pwrok_o);
        end
        cycles(1);
        n_checks++;
        if (sleep_state_o !== 2'd1 || sys_pwrok_o !== 1'b1 || fetch_en_o !== exp_fetch) begin
            n_fail++;
            $display("FAIL pwron: ss=%0d pok=%0b fe=%0b, expected 1/1/%0b", sleep_state_o, sys_pwrok_o, fetch_en_o, exp_fetch);
        end
        reg_xfer(1'b0, 5'h0C, 32'h0, rd, rdy);
        n_checks++;
        if (rd !== 32'hA) begin
            n_fail++;
            $display("FAIL pwron_status: data=%h, expected a", rd);
        end
    endtask

    task automatic test_glitch();
        pwr_btn_ni = 1'b0;
        cycles(8);
        pwr_btn_ni = 1'b1;
        cycles(40);
        n_checks++;
        if (sleep_state_o !== 2'd1 || sys_pwrok_o !== 1'b1 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: ss=%0d pok=%0b irq=%0b, expected 1/1/0", sleep_state_o, sys_pwrok_o, irq_o);
        end
    endtask

    task automatic test_short_press();
        logic [31:0] rd;
        logic        rdy;
        pwr_btn_ni = 1'b0;
        cycles(100);
        pwr_btn_ni = 1'b1;
        cycles(30);
        n_checks++;
        if (sleep_state_o !== 2'd1 || sys_pwrok_o !== 1'b1 || irq_o !== EXP_IRQ) begin
            n_fail++;
            $display("FAIL short_press: ss=%0d pok=%0b irq=%0b, expected 1/1/%0b", sleep_state_o, sys_pwrok_o, irq_o, EXP_IRQ);
        end
        reg_xfer(1'b0, 5'h14, 32'h0, rd, rdy);
        n_checks++;
        if (rd !== {31'h0, EXP_IRQ}) begin
            n_fail++;
            $display("FAIL evt_read: data=%h, expected %0b", rd, EXP_IRQ);
        end
        reg_xfer(1'b1, 5'h14, 32'h1, rd, rdy);
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL evt_w1c: irq=%0b, expected 0", irq_o);
        end
        reg_xfer(1'b0, 5'h14, 32'h0, rd, rdy);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL evt_read_cleared: data=%h, expected 0", rd);
        end
    endtask

    // Two forced-off / power-on rounds; round 1 also races a FETCH_EN write
    // against the forced-off edge.
    task automatic test_on_off_cycle();
        logic [31:0] rd;
        logic        rdy;
        for (int it = 0; it < 2; it++) begin
            if (it == 0) reg_xfer(1'b1, 5'h08, 32'h1, rd, rdy);
            pwr_btn_ni = 1'b0;
            cycles(4018);
            n_checks++;
            if (sys_pwrok_o !== 1'b1 || sleep_state_o !== 2'd1 || fetch_en_o !== (it == 0)) begin
                n_fail++;
                $display("FAIL long_before[%0d]: pok=%0b ss=%0d fe=%0b, expected 1/1/%0b", it, sys_pwrok_o, sleep_state_o, fetch_en_o, it == 0);
            end
            if (it == 0) cycles(1);
            else         reg_xfer(1'b1, 5'h08, 32'h1, rd, rdy);
            n_checks++;
            if (sys_pwrok_o !== 1'b0 || sleep_state_o !== 2'd0 || fetch_en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL long_off[%0d]: pok=%0b ss=%0d fe=%0b, expected 0/0/0", it, sys_pwrok_o, sleep_state_o, fetch_en_o);
            end
            cycles(981);
            n_checks++;
            if (sys_pwrok_o !== 1'b0 || sleep_state_o !== 2'd0) begin
                n_fail++;
                $display("FAIL long_held[%0d]: pok=%0b ss=%0d, expected 0/0", it, sys_pwrok_o, sleep_state_o);
            end
            pwr_btn_ni = 1'b1;
            cycles(40);
            reg_xfer(1'b0, 5'h0C, 32'h0, rd, rdy);
            n_checks++;
            if (sys_pwrok_o !== 1'b0 || sleep_state_o !== 2'd0 || fetch_en_o !== 1'b0 || rd !== 32'h0) begin
                n_fail++;
                $display("FAIL long_released[%0d]: pok=%0b ss=%0d fe=%0b status=%h, expected 0/0/0/0", it, sys_pwrok_o, sleep_state_o, fetch_en_o, rd);
            end
            test_power_on(1'b0);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic        rdy;
        reg_xfer(1'b1, 5'h08, 32'h1, rd, rdy);
        reg_xfer(1'b1, 5'h00, 32'h1, rd, rdy);
        reg_xfer(1'b0, 5'h04, 32'h0, rd, rdy);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bootmode_o, boot_addr_o, fetch_en_o, sleep_state_o, sys_pwrok_o, irq_o,
             reg_if.reg_ready_o, reg_if.reg_rdata_o} !== {2'd0, 32'h1C00_8080, 1'b0, 2'd0, 3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: bm=%0d ba=%h fe=%0b ss=%0d pok=%0b irq=%0b rdy=%0b rd=%h, expected bm=0 ba=1c008080 rest 0",
                     bootmode_o, boot_addr_o, fetch_en_o, sleep_state_o, sys_pwrok_o, irq_o,
                     reg_if.reg_ready_o, reg_if.reg_rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_eoc();
        logic [31:0] rd;
        logic        rdy;
        exit_status_i = 32'h0;
        eoc_i = 1'b1;
        cycles(3);
        reg_xfer(1'b0, 5'h0C, 32'h0, rd, rdy);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL eoc_status: data=%h, expected 1", rd);
        end
        reg_xfer(1'b0, 5'h10, 32'h0, rd, rdy);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL exit_zero: data=%h, expected 0", rd);
        end
        eoc_i = 1'b0;
        cycles(4);
        exit_status_i = 32'hCAFE_0042;
        eoc_i = 1'b1;
        cycles(3);
        reg_xfer(1'b0, 5'h10, 32'h0, rd, rdy);
        n_checks++;
        if (rd !== 32'hCAFE_0042) begin
            n_fail++;
            $display("FAIL exit_capture: data=%h, expected cafe0042", rd);
        end
        exit_status_i = 32'h1234_5678;
        cycles(5);
        reg_xfer(1'b0, 5'h10, 32'h0, rd, rdy);
        n_checks++;
        if (rd !== 32'hCAFE_0042) begin
            n_fail++;
            $display("FAIL exit_hold: data=%h, expected cafe0042", rd);
        end
    endtask

    initial begin
        rst                = 1'b1;
        pwr_btn_ni         = 1'b1;
        eoc_i              = 1'b0;
        exit_status_i      = 32'h0;
        reg_if.reg_req_i   = 1'b0;
        reg_if.reg_we_i    = 1'b0;
        reg_if.reg_addr_i  = 5'h0;
        reg_if.reg_wdata_i = 32'h0;
        @(negedge clk);
        test_reset();
        test_reg_write();
        test_back_to_back();
        test_power_on(1'b1);
        test_glitch();
        test_short_press();
        test_on_off_cycle();
        test_async_reset();
        test_eoc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
